// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions and fill-level types for the ALU result stage.
// The ALU macros keep the legacy define.v names (DATA_WIDTH, ALU_* op codes,
// REG_ADDR_WIDTH). They are guarded so an existing define.v can supply them.

`ifndef ALU_DEFINES_DONE
`define ALU_DEFINES_DONE
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 8'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB 8'h02
`endif
`ifndef ALU_AND
`define ALU_AND 8'h03
`endif
`ifndef ALU_OR
`define ALU_OR  8'h04
`endif
`ifndef ALU_XOR
`define ALU_XOR 8'h05
`endif
`endif

package alu_result_stage_pkg;

    localparam int unsigned QUEUE_DEPTH = 2;

    // Occupancy of the two-entry result queue.
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_t;

    // Occupancy after one more entry is written (saturates at full).
    function automatic fill_t fill_inc(input fill_t f);
        fill_t r;
        case (f)
            FILL_EMPTY: r = FILL_ONE;
            default:    r = FILL_FULL;
        endcase
        return r;
    endfunction

    // Occupancy after one entry is removed (saturates at empty).
    function automatic fill_t fill_dec(input fill_t f);
        fill_t r;
        case (f)
            FILL_FULL: r = FILL_ONE;
            default:   r = FILL_EMPTY;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_result_fifo2.sv
// Generic two-entry in-order queue. Entry 0 is always the head, so the head
// output is a plain register with no read mux.

module alu_result_fifo2
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output fill_t            count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses writes even when the head leaves in the same cycle.
    assign do_push = push && (count != FILL_FULL);
    assign do_pop  = pop  && (count != FILL_EMPTY);

    // Queue storage and occupancy; both reset and flush empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= FILL_EMPTY;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    // Only reachable with one entry: the new word replaces the head.
                    entry0 <= wdata;
                end
                2'b10: begin
                    if (count == FILL_EMPTY) begin
                        entry0 <= wdata;
                    end else begin
                        entry1 <= wdata;
                    end
                    count <= fill_inc(count);
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    count  <= fill_dec(count);
                end
                default: begin
                end
            endcase
        end
    end

    assign head = entry0;

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU adder: queues up to two results for the
// register-file write port and keeps carry/zero flags from accepted ADDs.

module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     cr,
    input  logic [DATA_WIDTH-1:0]     add_result,
    input  logic [DATA_WIDTH-1:0]     add_addition,
    input  logic [REG_ADDR_WIDTH-1:0] dest,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [DATA_WIDTH-1:0]     out_high,
    output logic [REG_ADDR_WIDTH-1:0] out_dest,
    output logic                      out_wide,
    output logic                      flag_c,
    output logic                      flag_z
);

    localparam int ENTRY_W = 1 + REG_ADDR_WIDTH + 2 * DATA_WIDTH;

    fill_t              fill;
    logic               push;
    logic               pop;
    logic               is_add;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_head;

    // Handshake derives only from registered occupancy, never from in_*/out_ready.
    assign in_ready  = (fill != FILL_FULL);
    assign out_valid = (fill != FILL_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign is_add   = (cr == DATA_WIDTH'(`ALU_ADD));
    assign entry_in = {is_add, dest, add_addition, add_result};

    alu_result_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (entry_in),
        .count (fill),
        .head  (entry_head)
    );

    assign {out_wide, out_dest, out_high, out_data} = entry_head;

    // Flags follow accepted ADDs; a push dropped by flush still updates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (push && is_add) begin
            flag_c <= |add_addition;
            flag_z <= ~(|add_result) & ~(|add_addition);
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: table of single-result vectors plus hand-built
// backpressure, full/pop, flush and reset sequences, checked via a queue model.

`ifndef ALU_ADD
`define ALU_ADD 8'h01
`endif

module tb_alu_result_stage;

    localparam logic [7:0] OP_ADD = `ALU_ADD;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h05;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] cr = '0;
    logic [7:0] add_result = '0;
    logic [7:0] add_addition = '0;
    logic [3:0] dest = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [7:0] out_high;
    logic [3:0] out_dest;
    logic       out_wide;
    logic       flag_c;
    logic       flag_z;

    alu_result_stage #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cr           (cr),
        .add_result   (add_result),
        .add_addition (add_addition),
        .dest         (dest),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_high     (out_high),
        .out_dest     (out_dest),
        .out_wide     (out_wide),
        .flag_c       (flag_c),
        .flag_z       (flag_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] high;
        logic [3:0] dest;
        logic       wide;
    } exp_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] res;
        logic [7:0] add;
        logic [3:0] dst;
        logic       exp_wide;
        logic       exp_c;
        logic       exp_z;
    } vec_t;

    exp_t sb[$];
    logic mc = 1'b0;
    logic mz = 1'b0;
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_outputs();
        exp_t h;
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(sb.size() != 2));
        chk("flag_c", 32'(flag_c), 32'(mc));
        chk("flag_z", 32'(flag_z), 32'(mz));
        if (sb.size() != 0) begin
            h = sb[0];
            chk("out_data", 32'(out_data), 32'(h.data));
            chk("out_high", 32'(out_high), 32'(h.high));
            chk("out_dest", 32'(out_dest), 32'(h.dest));
            chk("out_wide", 32'(out_wide), 32'(h.wide));
        end
    endtask

    // Check current outputs, advance the model with the driven inputs, then clock.
    task automatic cycle();
        logic m_push;
        logic m_pop;
        exp_t e;
        @(negedge clk);
        check_outputs();
        m_push = in_valid && (sb.size() < 2);
        m_pop  = out_ready && (sb.size() > 0);
        if (rst) begin
            sb.delete();
            mc = 1'b0;
            mz = 1'b0;
        end else begin
            if (m_push && cr == OP_ADD) begin
                mc = |add_addition;
                mz = (add_result == 8'h00) && (add_addition == 8'h00);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (m_pop) void'(sb.pop_front());
                if (m_push) begin
                    e.data = add_result;
                    e.high = add_addition;
                    e.dest = dest;
                    e.wide = (cr == OP_ADD);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] r,
                         input logic [7:0] a, input logic [3:0] d);
        in_valid     = v;
        cr           = op;
        add_result   = r;
        add_addition = a;
        dest         = d;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_high"}, 32'(out_high), 32'd0);
        chk({tag, "_out_dest"}, 32'(out_dest), 32'd0);
        chk({tag, "_out_wide"}, 32'(out_wide), 32'd0);
        chk({tag, "_flag_c"}, 32'(flag_c), 32'd0);
        chk({tag, "_flag_z"}, 32'(flag_z), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{OP_ADD, 8'h34, 8'h01, 4'd3,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{OP_ADD, 8'h00, 8'h00, 4'd5,  1'b1, 1'b0, 1'b1};
        vecs[2] = '{OP_SUB, 8'h00, 8'h00, 4'd6,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{OP_AND, 8'h12, 8'hff, 4'd7,  1'b0, 1'b0, 1'b1};
        vecs[4] = '{OP_ADD, 8'hff, 8'h00, 4'd1,  1'b1, 1'b0, 1'b0};
        vecs[5] = '{OP_ADD, 8'h00, 8'h80, 4'd2,  1'b1, 1'b1, 1'b0};
        vecs[6] = '{OP_XOR, 8'h00, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{OP_ADD, 8'h00, 8'h00, 4'd15, 1'b1, 1'b0, 1'b1};

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // Table vectors: push one result with out_ready high, see it once, then drain.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].res, vecs[i].add, vecs[i].dst);
            cycle();
            drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_data", 32'(out_data), 32'(vecs[i].res));
            chk("tbl_wide", 32'(out_wide), 32'(vecs[i].exp_wide));
            chk("tbl_flag_c", 32'(flag_c), 32'(vecs[i].exp_c));
            chk("tbl_flag_z", 32'(flag_z), 32'(vecs[i].exp_z));
            cycle();
            cycle();
        end

        // Backpressure: two queued, third refused, head held, then ordered drain.
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 8'h11, 8'h00, 4'd1);
        cycle();
        drive(1'b1, OP_ADD, 8'h22, 8'h00, 4'd2);
        cycle();
        drive(1'b1, OP_ADD, 8'h33, 8'h00, 4'd3);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'(out_data), 32'h11);
        end
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
        out_ready = 1'b1;
        cycle();
        chk("bp_second", 32'(out_data), 32'h22);
        cycle();
        chk("bp_empty", 32'(out_valid), 32'd0);
        cycle();

        // Full plus pop: pop happens, push refused, in_ready returns.
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 8'h11, 8'h00, 4'd1);
        cycle();
        drive(1'b1, OP_ADD, 8'h22, 8'h00, 4'd2);
        cycle();
        drive(1'b1, OP_ADD, 8'h44, 8'h00, 4'd4);
        out_ready = 1'b1;
        cycle();
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
        out_ready = 1'b0;
        chk("fp_in_ready", 32'(in_ready), 32'd1);
        chk("fp_head", 32'(out_data), 32'h22);
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();

        // Simultaneous push and pop with one entry.
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 8'h11, 8'h00, 4'd1);
        cycle();
        drive(1'b1, OP_SUB, 8'h55, 8'h66, 4'd5);
        out_ready = 1'b1;
        cycle();
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
        out_ready = 1'b0;
        chk("pp_head", 32'(out_data), 32'h55);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();

        // Flush with carry set: queue empties, flags kept.
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 8'h10, 8'h01, 4'd1);
        cycle();
        drive(1'b1, OP_ADD, 8'h20, 8'h02, 4'd2);
        cycle();
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_flag_c", 32'(flag_c), 32'd1);
        cycle();

        // Flush with a simultaneous ADD push: entry dropped, flags updated.
        drive(1'b1, OP_ADD, 8'h30, 8'h03, 4'd3);
        cycle();
        drive(1'b1, OP_ADD, 8'h00, 8'h00, 4'd4);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
        chk("flp_valid", 32'(out_valid), 32'd0);
        chk("flp_flag_z", 32'(flag_z), 32'd1);
        chk("flp_flag_c", 32'(flag_c), 32'd0);
        cycle();

        // Reset mid-stream.
        drive(1'b1, OP_ADD, 8'h77, 8'h07, 4'd7);
        cycle();
        drive(1'b1, OP_ADD, 8'h88, 8'h08, 4'd8);
        cycle();
        drive(1'b1, OP_ADD, 8'h99, 8'h09, 4'd9);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
        check_all_zero("midrst");
        cycle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the ALU adder.
- Captures the adder's low word (add_result), high/carry word (add_addition), the op code (cr) and the destination register index.
- Buffers up to two results in a 2-entry in-order queue and presents them to the register-file write port over a valid/ready handshake.
- Maintains carry and zero status flags from accepted ADD results.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (8): operand/result word width; the `define sets the value.
- REG_ADDR_WIDTH, default 4: width of the destination register index.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous queue clear; flags are kept.
- in_valid  in  1  upstream ALU result valid.
- in_ready  out  1  stage can accept a result this cycle.
- cr  in  DATA_WIDTH  op code that accompanied the result.
- add_result  in  DATA_WIDTH  adder low word.
- add_addition  in  DATA_WIDTH  adder high/carry word.
- dest  in  REG_ADDR_WIDTH  destination register index.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file accepts head entry.
- out_data  out  DATA_WIDTH  head low word.
- out_high  out  DATA_WIDTH  head high word.
- out_dest  out  REG_ADDR_WIDTH  head destination.
- out_wide  out  1  head entry was an ADD; high word is meaningful.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.

Behaviour:
- Reset: count=0, both entries cleared, out_valid=0, out_data/out_high/out_dest/out_wide=0, flag_c=0, flag_z=0, in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation drops all queued entries with no write-out. rst has priority over flush.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != 2). It is derived from registered count only. When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0). Head outputs come directly from registers, with no combinational path from in_* to out_*.
- Latency: an accepted input is visible at the outputs on the next cycle when the queue was empty.
- Ordering is strict FIFO. Entry 0 is the head. On pop with count=2, entry 1 shifts to entry 0.
- Counter updates:
  - push only: count+1.
  - pop only: count-1.
  - push & pop with count=1: the new entry replaces the head; count stays 1.
  - push & pop with count=0: impossible, since out_valid=0.
- Stored per entry: add_result, add_addition, dest, and wide = (cr == `ALU_ADD). A non-ADD op stores whatever is on the add_* inputs; the consumer ignores out_high when wide=0.
- Flags update on push, not pop, and only when cr == `ALU_ADD:
  - flag_c = |add_addition.
  - flag_z = (add_result == 0) & (add_addition == 0).
  - Visible the cycle after the push.
  - Non-ADD pushes leave the flags unchanged.
- flush: count→0 and out_valid=0 next cycle. A push in the same cycle as flush is discarded, but its flag update still applies. Flags are otherwise unaffected.
- Holding rule: while out_valid=1 and out_ready=0, out_* stay stable.
- Arithmetic: no width extension. Widths match the adder outputs exactly.

Decomposition:
- DATA_WIDTH and ALU_ADD and the other ALU op codes stay in define.v. Add REG_ADDR_WIDTH there.
- One sub-module, alu_result_fifo2: a generic 2-entry in-order queue with width parameter, push/pop/flush, count, and head outputs.
- alu_result_stage instantiates alu_result_fifo2 with a packed {wide, dest, addition, result} word and adds flag logic plus handshake glue.

Test Plan (DATA_WIDTH=8):
- Single ADD: cr=`ALU_ADD, result=0x34, addition=0x01, dest=3, out_ready=1 → next cycle out_valid=1, out_data=0x34, out_high=0x01, out_dest=3, out_wide=1; flag_c=1, flag_z=0; then out_valid=0.
- Zero result: ADD with result=0x00, addition=0x00 → flag_z=1, flag_c=0. A following non-ADD push with result=0x00 leaves flags unchanged and produces out_wide=0.
- Backpressure: out_ready=0, push A(0x11) and B(0x22) → in_ready=0 after the second push. A third in_valid is not accepted. Hold 3 cycles: out_data stays 0x11. Raise out_ready → 0x11 then 0x22 in order.
- Full plus pop: at count=2 assert in_valid and out_ready together → the pop occurs, the push is refused, count=1, and in_ready=1 next cycle.
- Simultaneous push/pop at count=1: head 0x11 popped, new 0x55 pushed in the same cycle → next cycle out_data=0x55, count=1.
- Flush/reset: two entries queued, flags c=1 → flush gives out_valid=0 with flag_c still 1. Reset asserted mid-stream gives all outputs 0 next cycle.
